aes128_decrypt_iter: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 decryption). It is the receive-side counterpart of the existing aes128 encryption core. It takes a 128-bit ciphertext and a 128-bit cipher key, and returns the plaintext after a fixed multi-cycle latency. Valid/ready handshakes on input and output let the block sit behind the aes128 core in out-of-context round-trip builds, and in system datapaths.

---
 rtl/aes128_decrypt_iter.sv | 192 +++++++++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: expands the key forward to round key 10, then
// unwinds the schedule one round per cycle alongside the inverse round datapath.
module aes128_decrypt_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_t;

    state_t       state_reg;
    logic [127:0] st_reg;
    logic [127:0] rk_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   cnt_reg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl(y, 3'd1) ^ rotl(y, 3'd2) ^ rotl(y, 3'd3) ^ rotl(y, 3'd4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl(x, 3'd1) ^ rotl(x, 3'd3) ^ rotl(x, 3'd6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
    endfunction

    // Key schedule: one g() shared between the forward and inverse steps.
    logic [31:0]  w0, w1, w2, w3, w1p, w2p, w3p;
    logic [31:0]  g_in, g_rot, g_sub, g_out;
    logic [127:0] rk_next, rk_prev;

    assign w0  = rk_reg[127:96];
    assign w1  = rk_reg[95:64];
    assign w2  = rk_reg[63:32];
    assign w3  = rk_reg[31:0];
    assign w1p = w1 ^ w0;
    assign w2p = w2 ^ w1;
    assign w3p = w3 ^ w2;

    assign g_in  = (state_reg == ROUND) ? w3p : w3;
    assign g_rot = {g_in[23:0], g_in[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fwd_sbox
            assign g_sub[31-8*gi -: 8] = sbox_fwd(g_rot[31-8*gi -: 8]);
        end
    endgenerate

    assign g_out = g_sub ^ {rcon_reg, 24'h000000};

    logic [31:0] n0, n1, n2, n3;
    assign n0      = w0 ^ g_out;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};
    assign rk_prev = {w0 ^ g_out, w1p, w2p, w3p};

    // Round datapath; byte n sits at row n%4, column n/4.
    logic [127:0] t;
    logic [127:0] imc;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sbox
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = 4 * ((C - R + 4) % 4) + R;
            assign t[127-8*gi -: 8] = sbox_inv(st_reg[127-8*SRC -: 8]) ^ rk_prev[127-8*gi -: 8];
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_imc
            logic [7:0] a0, a1, a2, a3;
            assign a0 = t[127-32*gi -: 8];
            assign a1 = t[119-32*gi -: 8];
            assign a2 = t[111-32*gi -: 8];
            assign a3 = t[103-32*gi -: 8];
            assign imc[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            assign imc[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            assign imc[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            assign imc[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    endgenerate

    assign in_ready = (state_reg == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            st_reg    <= '0;
            rk_reg    <= '0;
            rcon_reg  <= '0;
            cnt_reg   <= '0;
            out_valid <= 1'b0;
            plaintext <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st_reg    <= ciphertext;
                        rk_reg    <= key;
                        rcon_reg  <= 8'h01;
                        cnt_reg   <= 4'd0;
                        state_reg <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    rk_reg <= rk_next;
                    // rcon stops at 0x36 so the first inverse step can reuse it.
                    if (cnt_reg == 4'd9) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= INIT;
                    end else begin
                        rcon_reg <= xtime(rcon_reg);
                        cnt_reg  <= cnt_reg + 4'd1;
                    end
                end
                INIT: begin
                    st_reg    <= st_reg ^ rk_reg;
                    cnt_reg   <= 4'd0;
                    state_reg <= ROUND;
                end
                ROUND: begin
                    rk_reg   <= rk_prev;
                    rcon_reg <= inv_xtime(rcon_reg);
                    if (cnt_reg == 4'd9) begin
                        st_reg    <= t;
                        plaintext <= t;
                        out_valid <= 1'b1;
                        cnt_reg   <= 4'd0;
                        state_reg <= DONE;
                    end else begin
                        st_reg  <= imc;
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Directed bench for aes128_decrypt_iter: FIPS vectors, backpressure, reset, and
// round trips through a table-driven encryption model.
module tb_aes128_decrypt_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    int errors = 0;
    int checks = 0;

    aes128_decrypt_iter dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic [7:0] sbox_t [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward S-box table from the generator-3 log walk.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int n = 0; n < 16; n++) u[n] = sbox_t[s[n]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[4*c+rr] = u[4*((c+rr)%4)+rr];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rd + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = s[n];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept one block on the next edge, then count edges until out_valid.
    task automatic decrypt(input logic [127:0] ct, input logic [127:0] k, input bit scramble,
                           output logic [127:0] pt, output int lat, output bit busy_ready);
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        lat        = 0;
        busy_ready = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ready = 1'b1;
            if (scramble) begin
                ciphertext = {$urandom, $urandom, $urandom, $urandom};
                key        = {$urandom, $urandom, $urandom, $urandom};
                in_valid   = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        pt       = plaintext;
    endtask

    logic [127:0] pt, rt_pt, rt_key, rt_ct;
    int           lat;
    bit           br;
    int           bad;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        ciphertext = '0;
        key        = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'd0);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_plaintext", plaintext, 128'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        decrypt(CT_C1, KEY_C1, 1'b0, pt, lat, br);
        $display("txn c1: pt=%h latency=%0d", pt, lat);
        chk("c1_plaintext", pt, PT_C1);
        chk("c1_latency", 128'(lat), 128'd21);
        chk("c1_in_ready_busy", 128'(br), 128'd0);
        @(posedge clk); #1;
        chk("c1_handshake_out_valid", 128'(out_valid), 128'd0);
        chk("c1_handshake_in_ready", 128'(in_ready), 128'd1);

        decrypt(CT_B, KEY_B, 1'b0, pt, lat, br);
        $display("txn appB: pt=%h latency=%0d", pt, lat);
        chk("appb_plaintext", pt, PT_B);
        chk("appb_latency", 128'(lat), 128'd21);
        @(posedge clk); #1;

        decrypt(CT_Z, 128'd0, 1'b0, pt, lat, br);
        $display("txn zero: pt=%h latency=%0d", pt, lat);
        chk("zero_plaintext", pt, 128'd0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        decrypt(CT_C1, KEY_C1, 1'b0, pt, lat, br);
        chk("bp_plaintext", pt, PT_C1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid   = 1'b1;
            ciphertext = CT_B;
            key        = KEY_B;
            @(posedge clk); #1;
            if (!(out_valid === 1'b1 && plaintext === PT_C1 && in_ready === 1'b0)) bad++;
        end
        $display("txn backpressure: held 50 cycles, unstable=%0d", bad);
        chk("bp_stable", 128'(bad), 128'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        decrypt(CT_B, KEY_B, 1'b0, pt, lat, br);
        $display("txn after-bp: pt=%h latency=%0d", pt, lat);
        chk("bp_next_plaintext", pt, PT_B);
        chk("bp_next_latency", 128'(lat), 128'd21);
        @(posedge clk); #1;

        ciphertext = CT_C1;
        key        = KEY_C1;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_plaintext", plaintext, 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        chk("midrst_hold_plaintext", plaintext, 128'd0);
        reset = 1'b0;
        #1;
        decrypt(CT_C1, KEY_C1, 1'b0, pt, lat, br);
        $display("txn after-reset: pt=%h latency=%0d", pt, lat);
        chk("midrst_plaintext_after", pt, PT_C1);
        chk("midrst_latency_after", 128'(lat), 128'd21);
        @(posedge clk); #1;

        decrypt(CT_B, KEY_B, 1'b1, pt, lat, br);
        $display("txn scramble: pt=%h latency=%0d", pt, lat);
        chk("immunity_plaintext", pt, PT_B);
        chk("immunity_latency", 128'(lat), 128'd21);
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            rt_pt  = {$urandom, $urandom, $urandom, $urandom};
            rt_key = {$urandom, $urandom, $urandom, $urandom};
            rt_ct  = enc(rt_pt, rt_key);
            decrypt(rt_ct, rt_key, 1'b0, pt, lat, br);
            $display("txn rt%0d: key=%h ct=%h pt=%h", i, rt_key, rt_ct, pt);
            chk("roundtrip_plaintext", pt, rt_pt);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
